// File: rtl/sid_bus_pkg.sv
// Shared types and defaults for the SID bus writer.
package sid_bus_pkg;

    localparam int unsigned SID_ADDR_W     = 5;
    localparam int unsigned SID_DATA_W     = 8;
    localparam int unsigned ENTRY_W        = SID_ADDR_W + SID_DATA_W;
    localparam int unsigned DEF_CLK_DIV    = 8;
    localparam int unsigned DEF_RES_CYCLES = 10;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {StHold, StIdle, StWrite, StGap} state_e;

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous FIFO of queued {addr,data} SID register writes.
module sid_wr_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 13
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sid_bus_writer.sv
// Queues register writes and replays them onto the SID bus, one write per SID cycle pair,
// after holding the SID in reset for a fixed number of SID clocks.
module sid_bus_writer
    import sid_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned RES_CYCLES = DEF_RES_CYCLES,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  C6_CLK_8MHZ,
    input  logic                  BTN_0,
    input  logic                  WR_VALID,
    input  logic [SID_ADDR_W-1:0] WR_ADDR,
    input  logic [SID_DATA_W-1:0] WR_DATA,
    output logic                  WR_READY,
    output logic                  BUSY,
    output logic                  SID_CLK,
    output logic                  SID_NOTRES,
    output logic                  SID_NOTCS,
    output logic [SID_ADDR_W-1:0] SID_ADDR,
    output logic [SID_DATA_W-1:0] SID_DATA
);

    localparam int unsigned PhW  = $clog2(CLK_DIV);
    localparam int unsigned ResW = $clog2(RES_CYCLES + 1);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PhW-1:0]  PhLast  = PhW'(CLK_DIV - 1);
    localparam logic [ResW-1:0] ResLast = ResW'(RES_CYCLES - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    state_e                state_q;
    logic [PhW-1:0]        ph_q, ph_d;
    logic [ResW-1:0]       res_cnt_q;
    logic                  sid_clk_q, notres_q, notcs_q, wr_ready_q;
    logic [SID_ADDR_W-1:0] addr_q;
    logic [SID_DATA_W-1:0] data_q;
    logic                  push, pop, boundary;
    logic [CntW-1:0]       fifo_count, count_next;
    logic [ENTRY_W-1:0]    fifo_head;

    // CLK_DIV is a power of two, so the phase counter wraps on its own.
    assign ph_d       = ph_q + PhW'(1);
    assign boundary   = (ph_q == PhLast);
    assign push       = WR_VALID && wr_ready_q;
    // Uses the pre-edge count, so an entry pushed on a boundary edge waits one SID cycle.
    assign pop        = boundary && (state_q == StIdle || state_q == StGap) && (fifo_count != '0);
    assign count_next = fifo_count + CntW'(push) - CntW'(pop);

    sid_wr_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (ENTRY_W)
    ) u_fifo (
        .clk_i   (C6_CLK_8MHZ),
        .rst_i   (BTN_0),
        .push_i  (push),
        .wdata_i ({WR_ADDR, WR_DATA}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    always_ff @(posedge C6_CLK_8MHZ) begin
        if (BTN_0) begin
            state_q    <= StHold;
            ph_q       <= '0;
            res_cnt_q  <= '0;
            sid_clk_q  <= 1'b0;
            notres_q   <= 1'b0;
            notcs_q    <= 1'b1;
            wr_ready_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            ph_q       <= ph_d;
            sid_clk_q  <= ph_d[PhW-1];
            wr_ready_q <= (count_next < CntFull);
            if (pop) begin
                {addr_q, data_q} <= fifo_head;
                notcs_q          <= 1'b0;
                state_q          <= StWrite;
            end else if (boundary) begin
                case (state_q)
                    StHold: begin
                        if (res_cnt_q == ResLast) begin
                            state_q  <= StIdle;
                            notres_q <= 1'b1;
                        end else begin
                            res_cnt_q <= res_cnt_q + ResW'(1);
                        end
                    end
                    StWrite: begin
                        notcs_q <= 1'b1;
                        state_q <= StGap;
                    end
                    StGap:   state_q <= StIdle;
                    default: ;
                endcase
            end
        end
    end

    assign WR_READY   = wr_ready_q;
    assign BUSY       = (state_q != StIdle) || (fifo_count != '0);
    assign SID_CLK    = sid_clk_q;
    assign SID_NOTRES = notres_q;
    assign SID_NOTCS  = notcs_q;
    assign SID_ADDR   = addr_q;
    assign SID_DATA   = data_q;

endmodule

// File: tb/tb_sid_bus_writer.sv
// Directed, table-driven bench for sid_bus_writer with default parameters.
module tb_sid_bus_writer;

    logic       clk;
    logic       BTN_0;
    logic       WR_VALID;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       WR_READY, BUSY, SID_CLK, SID_NOTRES, SID_NOTCS;
    logic [4:0] SID_ADDR;
    logic [7:0] SID_DATA;

    sid_bus_writer dut (
        .C6_CLK_8MHZ (clk),
        .BTN_0       (BTN_0),
        .WR_VALID    (WR_VALID),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .WR_READY    (WR_READY),
        .BUSY        (BUSY),
        .SID_CLK     (SID_CLK),
        .SID_NOTRES  (SID_NOTRES),
        .SID_NOTCS   (SID_NOTCS),
        .SID_ADDR    (SID_ADDR),
        .SID_DATA    (SID_DATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Chip-select pulse monitor, updated once per sampled cycle.
    int         fall_cyc[$];
    logic [4:0] fall_addr[$];
    logic [7:0] fall_data[$];
    int         pulse_len[$];
    int         low_len = 0;
    int         bus_glitch = 0;
    logic       prev_ncs = 1'b1;
    logic [4:0] cur_addr;
    logic [7:0] cur_data;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         phase;
        logic [4:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_lat;
        int         exp_len;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_ncs && !SID_NOTCS) begin
            fall_cyc.push_back(cyc);
            fall_addr.push_back(SID_ADDR);
            fall_data.push_back(SID_DATA);
            cur_addr = SID_ADDR;
            cur_data = SID_DATA;
            low_len  = 1;
        end else if (!SID_NOTCS) begin
            low_len++;
            if (SID_ADDR != cur_addr || SID_DATA != cur_data) bus_glitch++;
        end else if (!prev_ncs) begin
            pulse_len.push_back(low_len);
        end
        prev_ncs = SID_NOTCS;
    endtask

    task automatic clear_mon();
        fall_cyc.delete();
        fall_addr.delete();
        fall_data.delete();
        pulse_len.delete();
        bus_glitch = 0;
    endtask

    task automatic do_reset(input int n);
        BTN_0 = 1'b1;
        WR_VALID = 1'b0;
        repeat (n) tick();
        check("rst_sid_clk", SID_CLK, 0);
        check("rst_notres", SID_NOTRES, 0);
        check("rst_notcs", SID_NOTCS, 1);
        check("rst_addr", SID_ADDR, 0);
        check("rst_data", SID_DATA, 0);
        check("rst_wr_ready", WR_READY, 0);
        check("rst_busy", BUSY, 1);
        BTN_0 = 1'b0;
        cyc = 0;
        clear_mon();
    endtask

    // Walks the 80-clock reset hold; optionally pushes two writes early in it.
    task automatic run_hold(input bit with_push);
        for (int i = 0; i < 80; i++) begin
            WR_VALID = 1'b0;
            if (with_push && cyc == 1) begin
                WR_VALID = 1'b1; WR_ADDR = 5'h04; WR_DATA = 8'h11;
            end else if (with_push && cyc == 2) begin
                WR_VALID = 1'b1; WR_ADDR = 5'h05; WR_DATA = 8'h22;
            end
            tick();
            if (cyc == 1) check("hold_wr_ready", WR_READY, 1);
            check("hold_notres", SID_NOTRES, (cyc >= 80) ? 1 : 0);
            check("hold_sid_clk", SID_CLK, ((cyc % 8) >= 4) ? 1 : 0);
            if (cyc < 80) check("hold_busy", BUSY, 1);
        end
        WR_VALID = 1'b0;
        check("hold_no_cs", fall_cyc.size(), 0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY && n < 64) begin
            tick();
            n++;
        end
        check(name, BUSY, 0);
    endtask

    task automatic wait_falls(input int want, input int bound, input string name);
        int n = 0;
        while (fall_cyc.size() < want && n < bound) begin
            tick();
            n++;
        end
        check(name, fall_cyc.size(), want);
    endtask

    task automatic wait_lens(input int want, input int bound, input string name);
        int n = 0;
        while (pulse_len.size() < want && n < bound) begin
            tick();
            n++;
        end
        check(name, pulse_len.size(), want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int base, push_cyc, stalls, n;
        logic acc;

        // phase = ph sampled before the push edge; latency to the next wrap edge
        vecs[0] = '{5'h18, 8'h0F, 0, 5'h18, 8'h0F, 7, 8};
        vecs[1] = '{5'h1F, 8'hFF, 6, 5'h1F, 8'hFF, 1, 8};
        vecs[2] = '{5'h00, 8'hA5, 3, 5'h00, 8'hA5, 4, 8};
        vecs[3] = '{5'h0B, 8'h3C, 7, 5'h0B, 8'h3C, 8, 8};

        BTN_0 = 1'b1;
        WR_VALID = 1'b0;
        WR_ADDR = '0;
        WR_DATA = '0;

        do_reset(16);
        run_hold(1'b0);

        foreach (vecs[v]) begin
            wait_idle("vec_idle");
            while ((cyc % 8) != vecs[v].phase) tick();
            clear_mon();
            WR_VALID = 1'b1;
            WR_ADDR  = vecs[v].addr;
            WR_DATA  = vecs[v].data;
            tick();
            WR_VALID = 1'b0;
            push_cyc = cyc;
            wait_falls(1, 16, "vec_fall");
            if (fall_cyc.size() > 0) begin
                check("vec_latency", fall_cyc[0] - push_cyc, vecs[v].exp_lat);
                check("vec_boundary", fall_cyc[0] % 8, 0);
                check("vec_addr", fall_addr[0], vecs[v].exp_addr);
                check("vec_data", fall_data[0], vecs[v].exp_data);
            end
            wait_lens(1, 16, "vec_rise");
            if (pulse_len.size() > 0) check("vec_len", pulse_len[0], vecs[v].exp_len);
            check("vec_bus_stable", bus_glitch, 0);
            check("vec_retain_addr", SID_ADDR, vecs[v].exp_addr);
            check("vec_retain_data", SID_DATA, vecs[v].exp_data);
        end

        // Burst of five into a four-deep FIFO
        wait_idle("burst_idle");
        while ((cyc % 8) != 0) tick();
        clear_mon();
        base = cyc;
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            WR_VALID = 1'b1;
            WR_ADDR  = 5'(i);
            WR_DATA  = 8'h40 + 8'(i);
            n = 0;
            do begin
                acc = WR_READY;
                tick();
                if (!acc) stalls++;
                n++;
            end while (!acc && n < 32);
            if (i == 3) check("burst_ready_low", WR_READY, 0);
        end
        WR_VALID = 1'b0;
        check("burst_stalls", stalls, 4);
        wait_falls(5, 100, "burst_falls");
        wait_lens(5, 32, "burst_rises");
        if (fall_cyc.size() == 5) begin
            check("burst_first", fall_cyc[0] - base, 8);
            for (int i = 0; i < 5; i++) begin
                check("burst_addr", fall_addr[i], i);
                check("burst_data", fall_data[i], 'h40 + i);
                if (i > 0) check("burst_spacing", fall_cyc[i] - fall_cyc[i-1], 16);
            end
        end
        for (int i = 0; i < pulse_len.size(); i++) check("burst_len", pulse_len[i], 8);
        check("burst_bus_stable", bus_glitch, 0);

        // Writes queued during the reset hold
        do_reset(4);
        run_hold(1'b1);
        wait_lens(2, 48, "hold_q_rises");
        if (fall_cyc.size() == 2) begin
            check("hold_q_fall0", fall_cyc[0], 88);
            check("hold_q_fall1", fall_cyc[1], 104);
            check("hold_q_addr0", fall_addr[0], 'h04);
            check("hold_q_data0", fall_data[0], 'h11);
            check("hold_q_addr1", fall_addr[1], 'h05);
            check("hold_q_data1", fall_data[1], 'h22);
        end else begin
            check("hold_q_falls", fall_cyc.size(), 2);
        end
        for (int i = 0; i < pulse_len.size(); i++) check("hold_q_len", pulse_len[i], 8);

        // Reset pulse mid-write with two entries still queued
        wait_idle("abort_idle");
        while ((cyc % 8) != 0) tick();
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            WR_VALID = 1'b1;
            WR_ADDR  = 5'h10 + 5'(i);
            WR_DATA  = 8'h80 + 8'(i);
            tick();
        end
        WR_VALID = 1'b0;
        wait_falls(1, 16, "abort_fall");
        repeat (3) tick();
        check("abort_in_write", SID_NOTCS, 0);
        do_reset(1);
        run_hold(1'b0);
        repeat (40) tick();
        check("abort_discard", fall_cyc.size(), 0);
        check("abort_fifo_empty", BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
